// File: rtl/wb_commit_unit.sv
// Writeback / commit stage. Holds the WB pipeline register, commits register-file
// and CSR writes, stalls loads until their data returns, and turns the highest
// priority exception source into an ecode / BADV report plus a one-cycle flush.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | no load waiting on data_rvalid
// S_WAIT_LD | a load without exception sits in WB awaiting its data
module wb_commit_unit #(
    parameter int                      NUM_EX     = 6,
    parameter logic [6*NUM_EX-1:0]     ECODE_LIST = {6'h0d, 6'h0c, 6'h0b, 6'h09, 6'h08, 6'h00},
    parameter logic [NUM_EX-1:0]       BADV_MASK  = 6'b000110,
    parameter bit                      LOAD_WAIT  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    input  logic [31:0]       ms_pc,
    input  logic [31:0]       ms_badv,
    input  logic [3:0]        ms_rf_we,
    input  logic [4:0]        ms_rf_waddr,
    input  logic [31:0]       ms_rf_wdata,
    input  logic              ms_is_load,
    input  logic              ms_csr_we,
    input  logic [13:0]       ms_csr_num,
    input  logic [31:0]       ms_csr_wdata,
    input  logic [31:0]       ms_csr_wmask,
    input  logic [NUM_EX-1:0] ms_ex_vec,
    input  logic              ms_ertn,
    input  logic              has_int,
    input  logic              data_rvalid,
    input  logic [31:0]       data_rdata,
    output logic              ws_allow_in,
    output logic              ws_valid,
    output logic [3:0]        wb_rf_we,
    output logic [4:0]        wb_rf_waddr,
    output logic [31:0]       wb_rf_wdata,
    output logic              wb_csr_we,
    output logic [13:0]       wb_csr_num,
    output logic [31:0]       wb_csr_wdata,
    output logic [31:0]       wb_csr_wmask,
    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_badv,
    output logic              wb_badv_we,
    output logic              wb_ertn,
    output logic              wb_flush
);

    typedef enum logic {S_RUN, S_WAIT_LD} state_t;

    state_t             state, state_nxt;

    logic [31:0]        pc_reg, badv_reg, rf_wdata_reg;
    logic [31:0]        csr_wdata_reg, csr_wmask_reg;
    logic [3:0]         rf_we_reg;
    logic [4:0]         rf_waddr_reg;
    logic [13:0]        csr_num_reg;
    logic [NUM_EX-1:0]  ex_vec_reg;
    logic               is_load_reg, csr_we_reg, ertn_reg;

    logic               ld_buf_v;
    logic [31:0]        ld_buf;

    logic [NUM_EX-1:0]  ex_eff;
    logic               any_ex;
    logic [5:0]         ecode_sel;
    logic               badv_sel;
    logic               rvalid_live;
    logic               ready_go;
    logic               commit;
    logic               accept;
    logic               load_accept;

    // Interrupt joins source 0 only at the moment of commit; nothing remembers it.
    assign ex_eff      = ex_vec_reg | {{(NUM_EX-1){1'b0}}, has_int};
    assign any_ex      = |ex_eff;

    // Load data is only meaningful while a load is actually waiting for it.
    assign rvalid_live = LOAD_WAIT && (state == S_WAIT_LD) && data_rvalid;

    assign ready_go    = any_ex || !is_load_reg || !LOAD_WAIT || rvalid_live || ld_buf_v;
    assign commit      = ws_valid && ready_go;
    assign ws_allow_in = !ws_valid || ready_go;

    assign accept      = ms_to_ws_valid && ws_allow_in && !wb_flush;
    assign load_accept = accept && LOAD_WAIT && ms_is_load && (ms_ex_vec == '0);

    // Fixed priority: walk from the top so the lowest set index ends up selected.
    always_comb begin
        ecode_sel = 6'h00;
        badv_sel  = 1'b0;
        for (int i = NUM_EX - 1; i >= 0; i--) begin
            if (ex_eff[i]) begin
                ecode_sel = ECODE_LIST[6*i +: 6];
                badv_sel  = BADV_MASK[i];
            end
        end
    end

    // WB pipeline register; every field resets so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= '0;
            badv_reg      <= '0;
            rf_we_reg     <= '0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            is_load_reg   <= 1'b0;
            csr_we_reg    <= 1'b0;
            csr_num_reg   <= '0;
            csr_wdata_reg <= '0;
            csr_wmask_reg <= '0;
            ex_vec_reg    <= '0;
            ertn_reg      <= 1'b0;
        end else if (accept) begin
            pc_reg        <= ms_pc;
            badv_reg      <= ms_badv;
            rf_we_reg     <= ms_rf_we;
            rf_waddr_reg  <= ms_rf_waddr;
            rf_wdata_reg  <= ms_rf_wdata;
            is_load_reg   <= ms_is_load;
            csr_we_reg    <= ms_csr_we;
            csr_num_reg   <= ms_csr_num;
            csr_wdata_reg <= ms_csr_wdata;
            csr_wmask_reg <= ms_csr_wmask;
            ex_vec_reg    <= ms_ex_vec;
            ertn_reg      <= ms_ertn;
        end
    end

    // Valid bit: a flush kills the WB slot and drops whatever MEM offers alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (wb_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allow_in) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    // Load buffer holds data that arrived without committing; commit always empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_buf_v <= 1'b0;
            ld_buf   <= '0;
        end else if (commit) begin
            ld_buf_v <= 1'b0;
        end else if (rvalid_live) begin
            ld_buf_v <= 1'b1;
            ld_buf   <= data_rdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a new waiting load captured in the same cycle keeps us in WAIT_LD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (load_accept) begin
                    state_nxt = S_WAIT_LD;
                end
            end
            S_WAIT_LD: begin
                if (load_accept) begin
                    state_nxt = S_WAIT_LD;
                end else if (data_rvalid || commit) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Commit outputs: writes only on clean commits, pulses only on committing cycles.
    always_comb begin
        wb_rf_we     = (commit && !any_ex) ? rf_we_reg : 4'h0;
        wb_rf_waddr  = rf_waddr_reg;
        wb_rf_wdata  = rf_wdata_reg;
        if (LOAD_WAIT && is_load_reg) begin
            if (ld_buf_v) begin
                wb_rf_wdata = ld_buf;
            end else if (rvalid_live) begin
                wb_rf_wdata = data_rdata;
            end
        end
        wb_csr_we    = commit && !any_ex && csr_we_reg;
        wb_csr_num   = csr_num_reg;
        wb_csr_wdata = csr_wdata_reg;
        wb_csr_wmask = csr_wmask_reg;
        wb_ex        = commit && any_ex;
        wb_ecode     = any_ex ? ecode_sel : 6'h00;
        wb_esubcode  = 9'h000;
        wb_pc        = pc_reg;
        wb_badv      = badv_reg;
        wb_badv_we   = commit && any_ex && badv_sel;
        wb_ertn      = commit && !any_ex && ertn_reg;
        wb_flush     = commit && (any_ex || ertn_reg);
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Randomised bench for wb_commit_unit with a transaction-level reference model
// and a scoreboard drained by a monitor whenever WB commits.
module tb_wb_commit_unit;

    logic        clk, reset;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc, ms_badv, ms_rf_wdata, ms_csr_wdata, ms_csr_wmask;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic        ms_is_load, ms_csr_we, ms_ertn, has_int, data_rvalid;
    logic [13:0] ms_csr_num;
    logic [5:0]  ms_ex_vec;
    logic [31:0] data_rdata;
    logic        ws_allow_in, ws_valid;
    logic [3:0]  wb_rf_we;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
    logic        wb_csr_we;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_csr_wdata, wb_csr_wmask;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_badv;
    logic        wb_badv_we, wb_ertn, wb_flush;

    wb_commit_unit dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_badv(ms_badv),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_is_load(ms_is_load), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
        .ms_csr_wdata(ms_csr_wdata), .ms_csr_wmask(ms_csr_wmask),
        .ms_ex_vec(ms_ex_vec), .ms_ertn(ms_ertn), .has_int(has_int),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .ws_allow_in(ws_allow_in), .ws_valid(ws_valid),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
        .wb_csr_wdata(wb_csr_wdata), .wb_csr_wmask(wb_csr_wmask),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_badv(wb_badv), .wb_badv_we(wb_badv_we),
        .wb_ertn(wb_ertn), .wb_flush(wb_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, badv, rf_wdata, csr_wdata, csr_wmask, ld;
        logic [3:0]  rf_we;
        logic [4:0]  waddr;
        logic [13:0] csr_num;
        logic [5:0]  ex_vec;
        logic        is_load, csr_we, ertn, hint;
        int          d, gap;
    } instr_t;

    typedef struct {
        logic [31:0] pc, wdata, csr_wdata, csr_wmask, badv;
        logic [3:0]  rf_we;
        logic [4:0]  waddr;
        logic [13:0] csr_num;
        logic [5:0]  ecode;
        logic        csr_we, ex, badv_we, ertn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: what the architecture says one instruction's commit must look like.
    function automatic exp_t model(input instr_t x);
        exp_t       e;
        logic [5:0] eff;
        logic [5:0] ecode_tab [6];
        logic       badv_tab  [6];
        int         w;
        ecode_tab = '{6'h00, 6'h08, 6'h09, 6'h0b, 6'h0c, 6'h0d};
        badv_tab  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e = '{default: '0};
        e.pc = x.pc;
        eff = x.ex_vec | {5'b0, x.hint};
        if (eff != 6'b0) begin
            w = 0;
            while (!eff[w]) w++;
            e.ex      = 1'b1;
            e.ecode   = ecode_tab[w];
            e.badv_we = badv_tab[w];
            e.badv    = x.badv;
        end else begin
            e.rf_we     = x.rf_we;
            e.waddr     = x.waddr;
            e.wdata     = x.is_load ? x.ld : x.rf_wdata;
            e.csr_we    = x.csr_we;
            e.csr_num   = x.csr_num;
            e.csr_wdata = x.csr_wdata;
            e.csr_wmask = x.csr_wmask;
            e.ertn      = x.ertn;
        end
        return e;
    endfunction

    function automatic instr_t gen(input int i);
        instr_t x;
        x.pc        = $urandom;
        x.badv      = $urandom;
        x.rf_wdata  = $urandom;
        x.csr_wdata = $urandom;
        x.csr_wmask = $urandom;
        x.ld        = $urandom;
        x.rf_we     = 4'($urandom);
        x.waddr     = 5'($urandom);
        x.csr_num   = 14'($urandom);
        x.is_load   = ($urandom_range(0, 3) == 0);
        x.csr_we    = ($urandom_range(0, 3) == 0);
        x.ex_vec    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b0;
        x.hint      = ($urandom_range(0, 9) == 0);
        x.ertn      = !x.is_load && ($urandom_range(0, 9) == 0);
        x.d         = $urandom_range(0, 3);
        x.gap       = $urandom_range(0, 2);
        if (i <= 8) begin
            x.gap = 0; x.is_load = 1'b0; x.ex_vec = 6'b0; x.hint = 1'b0; x.ertn = 1'b0;
            x.rf_we = 4'hf;
            case (i)
                0, 1, 2, 3: x.waddr = 5'(i + 1);
                4: begin x.is_load = 1'b1; x.ld = 32'hdeadbeef; x.d = 3; end
                6: begin x.ex_vec = 6'b001010; x.badv = 32'h1003; end
                7: begin x.hint = 1'b1; x.csr_we = 1'b1; end
                8: begin x.ertn = 1'b1; x.csr_we = 1'b0; end
                default: ;
            endcase
        end
        return x;
    endfunction

    task automatic drive(input logic v, input instr_t x, input logic hi, input logic rv, input logic [31:0] rd);
        ms_to_ws_valid = v;
        ms_pc          = x.pc;
        ms_badv        = x.badv;
        ms_rf_we       = x.rf_we;
        ms_rf_waddr    = x.waddr;
        ms_rf_wdata    = x.rf_wdata;
        ms_is_load     = x.is_load;
        ms_csr_we      = x.csr_we;
        ms_csr_num     = x.csr_num;
        ms_csr_wdata   = x.csr_wdata;
        ms_csr_wmask   = x.csr_wmask;
        ms_ex_vec      = x.ex_vec;
        ms_ertn        = x.ertn;
        has_int        = hi;
        data_rvalid    = rv;
        data_rdata     = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a commit is a live WB slot that is allowed to move on.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ws_valid && ws_allow_in) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: pc %0h with empty scoreboard at %0t", wb_pc, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pc", 64'(wb_pc), 64'(e.pc));
                    chk("rf_we", 64'(wb_rf_we), 64'(e.rf_we));
                    if (e.rf_we != 4'h0) begin
                        chk("rf_waddr", 64'(wb_rf_waddr), 64'(e.waddr));
                        chk("rf_wdata", 64'(wb_rf_wdata), 64'(e.wdata));
                    end
                    chk("csr_we", 64'(wb_csr_we), 64'(e.csr_we));
                    if (e.csr_we) begin
                        chk("csr_num", 64'(wb_csr_num), 64'(e.csr_num));
                        chk("csr_wdata", 64'(wb_csr_wdata), 64'(e.csr_wdata));
                        chk("csr_wmask", 64'(wb_csr_wmask), 64'(e.csr_wmask));
                    end
                    chk("ex", 64'(wb_ex), 64'(e.ex));
                    if (e.ex) chk("ecode", 64'(wb_ecode), 64'(e.ecode));
                    chk("badv_we", 64'(wb_badv_we), 64'(e.badv_we));
                    if (e.badv_we) chk("badv", 64'(wb_badv), 64'(e.badv));
                    chk("ertn", 64'(wb_ertn), 64'(e.ertn));
                    chk("flush", 64'(wb_flush), 64'(e.ex | e.ertn));
                end
            end else begin
                chk("idle_quiet", 64'({wb_rf_we, wb_csr_we, wb_ex, wb_ertn, wb_flush, wb_badv_we}), 64'd0);
            end
        end
    end

    initial begin
        instr_t      x, v, z;
        logic        p_valid, p_wait, p_int;
        logic [31:0] p_data;
        int          p_d;

        z = '{default: '0};
        reset = 1'b1;
        drive(1'b0, z, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ws_valid", 64'(ws_valid), 64'd0);
        chk("rst_allow_in", 64'(ws_allow_in), 64'd1);
        chk("rst_pc", 64'(wb_pc), 64'd0);
        chk("rst_badv", 64'(wb_badv), 64'd0);
        chk("rst_rf_wdata", 64'(wb_rf_wdata), 64'd0);
        chk("rst_enables", 64'({wb_rf_we, wb_csr_we, wb_ex, wb_ertn, wb_flush, wb_badv_we}), 64'd0);
        chk("rst_ecode", 64'({wb_esubcode, wb_ecode}), 64'd0);
        reset = 1'b0;
        step();

        p_valid = 1'b0; p_wait = 1'b0; p_int = 1'b0; p_data = '0; p_d = 0;
        for (int i = 0; i < 160; i++) begin
            x = gen(i);
            if (p_valid && p_wait) begin
                repeat (p_d) begin
                    drive(1'b0, z, 1'b0, 1'b0, 32'h0);
                    #1;
                    chk("stall_allow_in", 64'(ws_allow_in), 64'd0);
                    step();
                end
            end
            drive(1'b1, x, p_valid & p_int, p_valid & p_wait, p_data);
            #1;
            chk("issue_allow_in", 64'(ws_allow_in), 64'd1);
            sb.push_back(model(x));
            step();
            p_valid = 1'b1;
            p_int   = x.hint;
            p_wait  = x.is_load && (x.ex_vec == 6'b0) && !x.hint;
            p_data  = x.ld;
            p_d     = x.d;
            if ((x.ex_vec != 6'b0) || x.hint || x.ertn) begin
                // Offered while the flush is up, so it must never commit.
                v = gen(1000);
                drive(1'b1, v, p_int, 1'b0, 32'h0);
                step();
                p_valid = 1'b0;
            end else if (!p_wait) begin
                repeat (x.gap) begin
                    drive(1'b0, z, p_valid ? p_int : 1'($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 3) == 0), $urandom);
                    step();
                    p_valid = 1'b0;
                end
            end
        end
        if (p_valid && p_wait) begin
            repeat (p_d) begin drive(1'b0, z, 1'b0, 1'b0, 32'h0); step(); end
            drive(1'b0, z, 1'b0, 1'b1, p_data);
            step();
        end else if (p_valid) begin
            drive(1'b0, z, p_int, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, z, 1'b0, 1'b0, 32'h0);
        repeat (3) step();

        // Reset while a load is waiting: the load is discarded and later data ignored.
        x = gen(1000);
        x.is_load = 1'b1; x.ex_vec = 6'b0; x.hint = 1'b0; x.ertn = 1'b0; x.rf_we = 4'hf;
        drive(1'b1, x, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, z, 1'b0, 1'b0, 32'h0);
        #1;
        chk("ld_wait_allow_in", 64'(ws_allow_in), 64'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_wait_ws_valid", 64'(ws_valid), 64'd0);
        chk("rst_wait_allow_in", 64'(ws_allow_in), 64'd1);
        drive(1'b0, z, 1'b0, 1'b1, 32'h12345678);
        #1;
        chk("rst_wait_no_write", 64'(wb_rf_we), 64'd0);
        step();
        x = gen(1000);
        x.is_load = 1'b0; x.ex_vec = 6'b0; x.hint = 1'b0; x.ertn = 1'b0;
        sb.push_back(model(x));
        drive(1'b1, x, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, z, 1'b0, 1'b0, 32'h0);
        repeat (3) step();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
